// File: rtl/audio_loop_fifo.sv
// Loopback sample buffer between the codec receive and transmit paths.
// Bit-clock frame strobes are synchronised here; prefill, overflow and underflow are handled in-block.
//   state | meaning
//   FILL  | queue words until PREFILL are held; dac_data held at 0
//   RUN   | one word popped to dac_data per transmit frame
module audio_loop_fifo #(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int PREFILL = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] adc_data,
  input  logic          rx_done,
  input  logic          tx_done,
  input  logic          play_enable,
  input  logic          clr_flags,
  output logic [DW-1:0] dac_data,
  output logic [AW:0]   fifo_level,
  output logic          playing,
  output logic          overflow,
  output logic          underflow
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_L   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PREFILL_L = (AW+1)'(PREFILL);

  state_t        state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [2**AW];
  logic [2:0]    rx_sync, tx_sync;
  logic          wr_stb, rd_stb;
  logic          full, empty;
  logic          pop, push, ovf_evt, unf_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '0;
      tx_sync <= '0;
    end else begin
      rx_sync <= {rx_sync[1:0], rx_done};
      tx_sync <= {tx_sync[1:0], tx_done};
    end
  end

  assign wr_stb = rx_sync[1] & ~rx_sync[2];
  assign rd_stb = tx_sync[1] & ~tx_sync[2];

  assign full  = (fifo_level == DEPTH_L);
  assign empty = (fifo_level == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign pop     = play_enable & (state == RUN) & rd_stb & ~empty;
  assign push    = play_enable & wr_stb & (~full | pop);
  assign ovf_evt = play_enable & wr_stb & full & ~pop;
  assign unf_evt = play_enable & (state == RUN) & rd_stb & empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      playing    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dac_data   <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow & ~clr_flags);
      underflow <= unf_evt | (underflow & ~clr_flags);
      if (!play_enable) begin
        state      <= FILL;
        playing    <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        dac_data   <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
        case (state)
          FILL: begin
            dac_data <= '0;
            if (fifo_level >= PREFILL_L) begin
              state   <= RUN;
              playing <= 1'b1;
            end
          end
          RUN: begin
            if (pop) begin
              dac_data <= mem[rd_ptr];
            end else if (unf_evt) begin
              dac_data <= '0;
              state    <= FILL;
              playing  <= 1'b0;
            end
          end
          default: begin
            state   <= FILL;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_loop_fifo.sv
// Directed bench for audio_loop_fifo: fill/playback, overflow, underflow, flush, level-hold and reset.
module tb_audio_loop_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adc_data;
  logic        rx_done, tx_done, play_enable, clr_flags;
  logic [31:0] dac_data;
  logic [4:0]  fifo_level;
  logic        playing, overflow, underflow;

  int checks = 0;
  int errors = 0;

  audio_loop_fifo #(.DW(32), .AW(4), .PREFILL(8)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .rx_done(rx_done),
    .tx_done(tx_done), .play_enable(play_enable), .clr_flags(clr_flags),
    .dac_data(dac_data), .fifo_level(fifo_level), .playing(playing),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rx(input logic [31:0] d);
    adc_data = d;
    rx_done  = 1'b1;
    tick(4);
    rx_done  = 1'b0;
    tick(4);
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    tick(4);
    tx_done = 1'b0;
    tick(4);
  endtask

  initial begin
    rst_n = 1'b0; adc_data = '0; rx_done = 0; tx_done = 0;
    play_enable = 1'b1; clr_flags = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst_dac", dac_data, 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_flags", {29'd0, playing, overflow, underflow}, 0);

    // prefill then ordered playback
    for (int i = 1; i <= 8; i++) pulse_rx(32'(i));
    check("fill_level", 32'(fifo_level), 8);
    check("fill_playing", 32'(playing), 1);
    tx_done = 1'b1;
    tick(2);
    check("pop_latency_early", dac_data, 0);
    tick(2);
    check("pop_latency", dac_data, 1);
    tx_done = 1'b0;
    tick(4);
    for (int i = 2; i <= 8; i++) begin
      pulse_tx();
      check($sformatf("play_%0d", i), dac_data, 32'(i));
    end
    check("drain_level", 32'(fifo_level), 0);

    // overflow: 20 writes, words 17..20 dropped
    for (int i = 1; i <= 20; i++) begin
      pulse_rx(32'h100 + 32'(i));
      if (i == 16) check("ovf_not_yet", 32'(overflow), 0);
    end
    check("ovf_level", 32'(fifo_level), 16);
    check("ovf_flag", 32'(overflow), 1);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    check("ovf_clr", 32'(overflow), 0);

    // simultaneous push/pop while full
    adc_data = 32'hAAAA_5555;
    rx_done = 1'b1; tx_done = 1'b1;
    tick(4);
    rx_done = 1'b0; tx_done = 1'b0;
    tick(4);
    check("sim_level", 32'(fifo_level), 16);
    check("sim_ovf", 32'(overflow), 0);
    check("sim_dac", dac_data, 32'h101);

    for (int i = 2; i <= 16; i++) begin
      pulse_tx();
      check($sformatf("ovf_order_%0d", i), dac_data, 32'h100 + 32'(i));
    end
    check("level_one", 32'(fifo_level), 1);

    // underflow
    pulse_tx();
    check("last_word", dac_data, 32'hAAAA_5555);
    check("unf_not_yet", 32'(underflow), 0);
    pulse_tx();
    check("unf_dac", dac_data, 0);
    check("unf_flag", 32'(underflow), 1);
    check("unf_playing", 32'(playing), 0);
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    tick(1);
    check("unf_clr", 32'(underflow), 0);

    // flush with level 5 in RUN
    for (int i = 1; i <= 8; i++) pulse_rx(32'h200 + 32'(i));
    for (int i = 0; i < 3; i++) pulse_tx();
    check("pre_flush_level", 32'(fifo_level), 5);
    check("pre_flush_dac", dac_data, 32'h203);
    check("pre_flush_playing", 32'(playing), 1);
    play_enable = 1'b0;
    tick(1);
    check("flush_level", 32'(fifo_level), 0);
    check("flush_dac", dac_data, 0);
    check("flush_playing", 32'(playing), 0);
    pulse_rx(32'h300);
    pulse_rx(32'h301);
    check("disabled_writes", 32'(fifo_level), 0);
    play_enable = 1'b1;
    tick(2);

    // level held high gives one write
    adc_data = 32'h400;
    rx_done = 1'b1;
    tick(100);
    rx_done = 1'b0;
    tick(4);
    check("hold_one_write", 32'(fifo_level), 1);
    check("hold_fill_state", 32'(playing), 0);
    for (int i = 1; i <= 7; i++) pulse_rx(32'h400 + 32'(i));
    pulse_tx();
    check("hold_word", dac_data, 32'h400);
    check("pre_rst_level", 32'(fifo_level), 7);

    // async reset mid-cycle
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dac", dac_data, 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_playing", 32'(playing), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_level", 32'(fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
